// File: rtl/dmem_port_arbiter.sv
// Purpose : shares the single data-memory port between the pipeline MEM stage and a debug/loader port.
// Latency : core access is combinational (zero added latency); a debug access is granted in cycle T and acked at T+1.
// Backpres: core_stall freezes the pipeline for the one cycle the debug side owns the port; dbg waits on dbg_ack.
//
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-low reset
//   core_rd/wr/addr/wdata/   MEM-stage access request; core_rdata returns load data,
//   core_func3               core_stall = 1 freezes PC..EX/MEM and bubbles MEM/WB
//   dbg_req/we/addr/wdata    debug request (level); dbg_ack pulses one cycle on completion,
//                            dbg_rdata holds the captured read data until the next debug grant
//   mem_rd/wr/addr/wdata/    datamemory port (mem_rdata is combinational from datamemory)
//   mem_func3, mem_rdata
//   stall_cnt                saturating count of cycles with core_stall = 1
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [0:0] S_ARB = 1'b0;
  localparam logic [0:0] S_ACK = 1'b1;

  // STARVE_MAX = 0 still needs a 1-bit register; it simply never leaves 0.
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [0:0]          state;
  logic [STARVE_W-1:0] starve;
  logic                core_req;
  logic                starve_hit;
  logic                dbg_grant;

  assign core_req   = core_rd | core_wr;
  assign starve_hit = (starve == STARVE_LIM);

  // Debug is never granted in the ACK cycle, which is what guarantees the stalled
  // core access is served on the very next cycle. Reset blocks any grant.
  assign dbg_grant = reset & (state == S_ARB) & dbg_req & (~core_req | starve_hit);

  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_func3 = core_func3;
    mem_rd    = core_rd & reset;
    mem_wr    = core_wr & reset;
    if (dbg_grant) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_func3 = 3'b010;
      mem_rd    = ~dbg_we;
      mem_wr    = dbg_we;
    end
  end

  assign core_stall = dbg_grant & core_req;
  assign core_rdata = mem_rdata;
  assign dbg_ack    = (state == S_ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_ARB;
      starve    <= '0;
      dbg_rdata <= '0;
      stall_cnt <= '0;
    end else begin
      if (dbg_grant) begin
        state     <= S_ACK;
        starve    <= '0;
        dbg_rdata <= mem_rdata;
      end else begin
        state <= S_ARB;
        // Starvation only accrues on ARB-cycle conflicts the core wins; the ACK cycle leaves it alone.
        if (state == S_ARB) begin
          if (!dbg_req) begin
            starve <= '0;
          end else if (core_req && !starve_hit) begin
            starve <= starve + 1'b1;
          end
        end
      end
      if (core_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose : exercises three arbiter configurations (STARVE_MAX 4/CNT_W 16, STARVE_MAX 0/CNT_W 16,
//           STARVE_MAX 0/CNT_W 2) with directed scenarios and randomized traffic against a
//           cycle-level reference model and a word-addressed memory.
module tb_dmem_port_arbiter;

  localparam int N = 3;

  function automatic int smax(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int cmax(int i);
    return (i == 2) ? 3 : 65535;
  endfunction

  logic clk;
  logic reset;

  logic        core_rd    [N];
  logic        core_wr    [N];
  logic [8:0]  core_addr  [N];
  logic [31:0] core_wdata [N];
  logic [2:0]  core_func3 [N];
  logic [31:0] core_rdata [N];
  logic        core_stall [N];
  logic        dbg_req    [N];
  logic        dbg_we     [N];
  logic [8:0]  dbg_addr   [N];
  logic [31:0] dbg_wdata  [N];
  logic        dbg_ack    [N];
  logic [31:0] dbg_rdata  [N];
  logic        mem_rd     [N];
  logic        mem_wr     [N];
  logic [8:0]  mem_addr   [N];
  logic [31:0] mem_wdata  [N];
  logic [2:0]  mem_func3  [N];
  logic [31:0] mem_rdata  [N];
  logic [15:0] stall_cnt  [N];

  // datamemory stand-in: combinational read, write on the rising edge
  logic [31:0] mem [N][128] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_wr[i]) mem[i][mem_addr[i][8:2]] <= mem_wdata[i];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 16;
    localparam int SM = (g == 0) ? 4 : 0;
    logic [CW-1:0] sc;

    dmem_port_arbiter #(
      .DATA_W(32), .DM_ADDRESS(9), .STARVE_MAX(SM), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .reset(reset),
      .core_rd(core_rd[g]), .core_wr(core_wr[g]), .core_addr(core_addr[g]),
      .core_wdata(core_wdata[g]), .core_func3(core_func3[g]),
      .core_rdata(core_rdata[g]), .core_stall(core_stall[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_ack(dbg_ack[g]), .dbg_rdata(dbg_rdata[g]),
      .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_func3(mem_func3[g]), .mem_rdata(mem_rdata[g]),
      .stall_cnt(sc)
    );

    assign stall_cnt[g] = 16'(sc);
    assign mem_rdata[g] = mem[g][mem_addr[g][8:2]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Port owner per cycle: debug wins when it asks outside an ack cycle and either the
  // core is idle or the core has already beaten it STARVE_MAX times in a row.
  bit          m_inack [N];
  int          m_starve[N];
  int          m_stall [N];
  logic [31:0] m_drd   [N];
  logic [31:0] m_mem   [N][128] = '{default: '0};
  bit          g_dbg   [N];
  bit          g_stall [N];

  task automatic eval_check(int i);
    bit          creq;
    bit          gd;
    logic [8:0]  ea;
    logic [31:0] ed;
    string       p;
    p    = $sformatf("u%0d.", i);
    creq = core_rd[i] | core_wr[i];
    if (!reset) begin
      g_dbg[i]   = 1'b0;
      g_stall[i] = 1'b0;
      check_val({p, "rst_mem_rd"},  32'(mem_rd[i]),     32'd0);
      check_val({p, "rst_mem_wr"},  32'(mem_wr[i]),     32'd0);
      check_val({p, "rst_stall"},   32'(core_stall[i]), 32'd0);
      check_val({p, "rst_ack"},     32'(dbg_ack[i]),    32'd0);
      check_val({p, "rst_drdata"},  dbg_rdata[i],       32'd0);
      check_val({p, "rst_scnt"},    32'(stall_cnt[i]),  32'd0);
      return;
    end
    gd = !m_inack[i] && dbg_req[i] && (!creq || m_starve[i] >= smax(i));
    g_dbg[i]   = gd;
    g_stall[i] = gd && creq;
    ea = gd ? dbg_addr[i]  : core_addr[i];
    ed = gd ? dbg_wdata[i] : core_wdata[i];
    check_val({p, "mem_rd"},    32'(mem_rd[i]),     32'(gd ? !dbg_we[i] : core_rd[i]));
    check_val({p, "mem_wr"},    32'(mem_wr[i]),     32'(gd ?  dbg_we[i] : core_wr[i]));
    check_val({p, "mem_addr"},  32'(mem_addr[i]),   32'(ea));
    check_val({p, "mem_wdata"}, mem_wdata[i],       ed);
    check_val({p, "mem_func3"}, 32'(mem_func3[i]),  32'(gd ? 3'b010 : core_func3[i]));
    check_val({p, "stall"},     32'(core_stall[i]), 32'(g_stall[i]));
    check_val({p, "ack"},       32'(dbg_ack[i]),    32'(m_inack[i]));
    check_val({p, "dbg_rdata"}, dbg_rdata[i],       m_drd[i]);
    check_val({p, "stall_cnt"}, 32'(stall_cnt[i]),  32'(m_stall[i]));
    if (!gd && core_rd[i])
      check_val({p, "core_rdata"}, core_rdata[i], m_mem[i][core_addr[i][8:2]]);
  endtask

  task automatic commit(int i);
    bit was_ack;
    bit creq;
    if (!reset) begin
      m_inack[i] = 1'b0; m_starve[i] = 0; m_stall[i] = 0; m_drd[i] = '0;
      return;
    end
    was_ack = m_inack[i];
    creq    = core_rd[i] | core_wr[i];
    if (g_dbg[i]) begin
      m_drd[i] = m_mem[i][dbg_addr[i][8:2]];
      if (dbg_we[i]) m_mem[i][dbg_addr[i][8:2]] = dbg_wdata[i];
      m_inack[i]  = 1'b1;
      m_starve[i] = 0;
    end else begin
      m_inack[i] = 1'b0;
      if (core_wr[i]) m_mem[i][core_addr[i][8:2]] = core_wdata[i];
      if (!was_ack) begin
        if (dbg_req[i] && creq) m_starve[i] = (m_starve[i] < smax(i)) ? m_starve[i] + 1 : smax(i);
        else if (!dbg_req[i])   m_starve[i] = 0;
      end
    end
    if (g_stall[i] && m_stall[i] < cmax(i)) m_stall[i]++;
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1;
    for (int i = 0; i < N; i++) eval_check(i);
    @(posedge clk);
    for (int i = 0; i < N; i++) commit(i);
    @(negedge clk);
  endtask

  task automatic core_all(bit rd, bit wr, logic [8:0] a, logic [31:0] d);
    for (int i = 0; i < N; i++) begin
      core_rd[i] = rd; core_wr[i] = wr; core_addr[i] = a;
      core_wdata[i] = d; core_func3[i] = 3'b010;
    end
  endtask

  task automatic dbg_all(bit req, bit we, logic [8:0] a, logic [31:0] d);
    for (int i = 0; i < N; i++) begin
      dbg_req[i] = req; dbg_we[i] = we; dbg_addr[i] = a; dbg_wdata[i] = d;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    core_all(0, 0, 9'h0, 32'h0);
    dbg_all(0, 0, 9'h0, 32'h0);
    cycle();
    reset = 1'b1;
  endtask

  bit dbg_pend[N];

  initial begin
    reset = 1'b0;
    core_all(0, 0, 9'h0, 32'h0);
    dbg_all(0, 0, 9'h0, 32'h0);
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // reset dropped in the middle of a debug grant
    dbg_all(1, 1, 9'h0F0, 32'hA5A5A5A5);
    #1;
    check_val("t1_grant_wr", 32'(mem_wr[0]), 32'd1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    dbg_all(0, 0, 9'h0, 32'h0);
    cycle();
    check_val("t1_no_ack", 32'(dbg_ack[0]), 32'd0);
    check_val("t1_not_written", mem[0][9'h0F0 >> 2], 32'h0);
    cycle();

    // core-only store then load
    core_all(0, 1, 9'h010, 32'hDEADBEEF);
    cycle();
    core_all(1, 0, 9'h010, 32'h0);
    #1;
    check_val("t2_rdata", core_rdata[0], 32'hDEADBEEF);
    check_val("t2_stall", 32'(core_stall[0]), 32'd0);
    cycle();
    core_all(0, 0, 9'h010, 32'h0);

    // debug write then read, request held through the ack cycle
    dbg_all(1, 1, 9'h020, 32'h12345678);
    #1;
    check_val("t3_wr_grant", 32'(mem_wr[0]), 32'd1);
    cycle();
    dbg_all(1, 0, 9'h020, 32'h0);
    #1;
    check_val("t3_wr_ack", 32'(dbg_ack[0]), 32'd1);
    check_val("t3_no_grant_in_ack", 32'(mem_rd[0]), 32'd0);
    cycle();
    #1;
    check_val("t3_rd_grant", 32'(mem_rd[0]), 32'd1);
    cycle();
    dbg_all(0, 0, 9'h0, 32'h0);
    #1;
    check_val("t3_rd_ack", 32'(dbg_ack[0]), 32'd1);
    check_val("t3_rd_data", dbg_rdata[0], 32'h12345678);
    cycle();

    // starvation with continuous core loads
    reset_pulse();
    core_all(1, 0, 9'h040, 32'h0);
    dbg_all(1, 0, 9'h044, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      #1;
      check_val($sformatf("t4_stall_c%0d", c), 32'(core_stall[0]), 32'(c == 5));
      cycle();
    end
    dbg_all(0, 0, 9'h0, 32'h0);
    #1;
    check_val("t4_ack", 32'(dbg_ack[0]), 32'd1);
    check_val("t4_stall_after", 32'(core_stall[0]), 32'd0);
    check_val("t4_stall_cnt", 32'(stall_cnt[0]), 32'd1);
    cycle();

    // debug always wins, same-address write/load
    reset_pulse();
    core_all(1, 0, 9'h030, 32'h0);
    dbg_all(1, 1, 9'h030, 32'h55);
    #1;
    check_val("t5_stall", 32'(core_stall[1]), 32'd1);
    check_val("t5_dbg_wr", 32'(mem_wr[1]), 32'd1);
    cycle();
    dbg_all(0, 0, 9'h0, 32'h0);
    #1;
    check_val("t5_unstall", 32'(core_stall[1]), 32'd0);
    check_val("t5_rdata", core_rdata[1], 32'h55);
    cycle();

    // stall counter saturation
    reset_pulse();
    core_all(1, 0, 9'h050, 32'h0);
    dbg_all(1, 0, 9'h054, 32'h0);
    for (int c = 0; c < 10; c++) cycle();
    core_all(0, 0, 9'h0, 32'h0);
    dbg_all(0, 0, 9'h0, 32'h0);
    #1;
    check_val("t6_sat", 32'(stall_cnt[2]), 32'd3);
    check_val("t6_wide", 32'(stall_cnt[1]), 32'd5);
    cycle();

    // randomized traffic
    reset_pulse();
    for (int i = 0; i < N; i++) dbg_pend[i] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if (!g_stall[i]) begin
          case ($urandom_range(0, 3))
            0:       begin core_rd[i] = 0; core_wr[i] = 0; end
            2:       begin core_rd[i] = 0; core_wr[i] = 1; end
            default: begin core_rd[i] = 1; core_wr[i] = 0; end
          endcase
          core_addr[i]  = 9'({4'($urandom_range(0, 15)), 2'b00});
          core_wdata[i] = $urandom;
          core_func3[i] = 3'($urandom_range(0, 7));
        end
        if (m_inack[i]) dbg_pend[i] = 1'b0;
        if (!dbg_pend[i] && $urandom_range(0, 2) == 0) begin
          dbg_pend[i]  = 1'b1;
          dbg_we[i]    = 1'($urandom_range(0, 1));
          dbg_addr[i]  = 9'({4'($urandom_range(0, 15)), 2'b00});
          dbg_wdata[i] = $urandom;
        end
        dbg_req[i] = dbg_pend[i];
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
